// File: rtl/imm_gen_pipe.sv
// Purpose: decode-stage immediate generator with a 2-entry output buffer and saturating illegal counter.
// Latency: one cycle from accept to out_* when the buffer is empty.
// Backpressure: in_ready = (count < 2) from registered state only; out_ready has no combinational path to in_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           dec;
    entry_t           mem_q [2];
    entry_t           mem_d [2];
    entry_t           head_q, head_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             push, pop;

    assign in_ready    = (cnt_q < 2'd2);
    assign out_valid   = (cnt_q != 2'd0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_imm     = head_q.imm;
    assign out_type    = head_q.typ;
    assign out_illegal = head_q.ill;
    assign out_tag     = head_q.tag;
    assign illegal_cnt = ill_cnt_q;

    // Decode the incoming instruction into {imm, type, illegal, tag}.
    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        case (in_inst[6:0])
            OPC_OP: dec.typ = T_NONE;
            OPC_OP_IMM: begin
                if (in_inst[14:12] == 3'b001 || in_inst[14:12] == 3'b101) begin
                    // Shift amount only; inst[30] selects SRA and is not immediate data.
                    dec.typ = T_SHAMT;
                    if (XLEN == 32) begin
                        if (in_inst[25]) begin
                            dec.ill = 1'b1;
                        end else begin
                            dec.imm = {{(XLEN-5){1'b0}}, in_inst[24:20]};
                        end
                    end else begin
                        dec.imm = {{(XLEN-6){1'b0}}, in_inst[25:20]};
                    end
                end else begin
                    dec.typ = T_I;
                    dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec.typ = T_I;
                dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            end
            OPC_STORE: begin
                dec.typ = T_S;
                dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_BRANCH: begin
                dec.typ = T_B;
                dec.imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.typ = T_U;
                dec.imm = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
            end
            OPC_JAL: begin
                dec.typ = T_J;
                dec.imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            default: dec.ill = 1'b1;
        endcase
    end

    // Buffer next state: flush wins over push; head register tracks the next head entry.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ill_cnt_d = ill_cnt_q;
        head_d    = head_q;
        if (flush) begin
            cnt_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = ~wr_ptr_q;
                if (dec.ill && !(&ill_cnt_q)) begin
                    ill_cnt_d = ill_cnt_q + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + 2'(push) - 2'(pop);
        end
        // An empty buffer leaves out_* at their last values.
        if (cnt_d != 2'd0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q     <= '{default: '0};
            head_q    <= '0;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            head_q    <= head_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

endmodule
